// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift controller.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } phase_state_t;

  // Output select values, matching the wrapper's clk_o[0..3] numbering
  localparam logic [1:0] SEL_OP  = 2'd0;
  localparam logic [1:0] SEL_OS  = 2'd1;
  localparam logic [1:0] SEL_OS2 = 2'd2;
  localparam logic [1:0] SEL_OS3 = 2'd3;

  localparam logic DIR_DELAY   = 1'b0;
  localparam logic DIR_ADVANCE = 1'b1;

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchroniser for the PLL lock signal followed by a consecutive-high filter.
module pll_lock_filter
  import pll_phase_pkg::*;
#(
  parameter int unsigned LOCK_CYC = 16
) (
  input  logic clk_i,
  input  logic reset,
  input  logic locked,
  output logic lock_ok
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYC + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= locked;
      sync_q2 <= sync_q1;
      if (!sync_q2) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(LOCK_CYC)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Drops in the same cycle the synchronised lock goes low
  assign lock_ok = sync_q2 && (cnt == CNT_W'(LOCK_CYC));

endmodule

// File: rtl/pll_phase_stepper.sv
// Sequences phasesel/phasedir/phasestep for the ECP5 PLL and tracks per-output phase offsets.
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned LOCK_CYC  = 16,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned ACC_W     = 12
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              done,
  output logic              err,
  input  logic              err_clr,
  input  logic [1:0]        rd_sel,
  output logic [ACC_W-1:0]  rd_phase,
  input  logic              locked,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg
);

  localparam int unsigned CYC_MAX0 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned CYC_MAX  = (CYC_MAX0 > GAP_CYC) ? CYC_MAX0 : GAP_CYC;
  localparam int unsigned CNT_W    = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  phase_state_t      state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [STEP_W-1:0] left, left_n;
  logic              set_err;
  logic              step_done;
  logic              phasestep_n;
  logic              done_n;
  logic              lock_ok;
  logic              accept;
  logic [ACC_W-1:0]  acc [4];

  pll_lock_filter #(
    .LOCK_CYC(LOCK_CYC)
  ) u_lock_filter (
    .clk_i  (clk_i),
    .reset  (reset),
    .locked (locked),
    .lock_ok(lock_ok)
  );

  assign req_ready    = (state == IDLE) && lock_ok;
  assign accept       = req_valid && req_ready;
  assign phaseloadreg = 1'b0;
  assign rd_phase     = acc[rd_sel];

  // Next-state, cycle/step counters and registered-output values
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    left_n    = left;
    set_err   = 1'b0;
    step_done = 1'b0;
    unique case (state)
      WAIT_LOCK: if (lock_ok) state_n = IDLE;
      IDLE: begin
        if (accept) begin
          cnt_n   = '0;
          left_n  = req_steps;
          state_n = (req_steps == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (!lock_ok) begin
          state_n = DONE;
          set_err = 1'b1;
        end else if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          cnt_n   = '0;
          state_n = PULSE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PULSE: begin
        // A pulse cut short by lock loss is not counted
        if (!lock_ok) begin
          state_n = DONE;
          set_err = 1'b1;
        end else if (cnt == CNT_W'(PULSE_CYC - 1)) begin
          cnt_n     = '0;
          left_n    = left - STEP_W'(1);
          step_done = 1'b1;
          state_n   = GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (!lock_ok) begin
          state_n = DONE;
          set_err = 1'b1;
        end else if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cnt_n   = '0;
          state_n = (left == '0) ? DONE : PULSE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE:    state_n = lock_ok ? IDLE : WAIT_LOCK;
      default: state_n = WAIT_LOCK;
    endcase
    phasestep_n = (state_n != PULSE);
    done_n      = (state_n == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      left      <= '0;
      phasesel  <= '0;
      phasedir  <= 1'b0;
      phasestep <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      left      <= left_n;
      phasestep <= phasestep_n;
      done      <= done_n;
      if (accept) begin
        phasesel <= req_sel;
        phasedir <= req_dir;
      end
      if (set_err) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (step_done) begin
        acc[phasesel] <= (phasedir == DIR_DELAY) ? acc[phasesel] + ACC_W'(1)
                                                 : acc[phasesel] - ACC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Randomized self-checking bench for pll_phase_stepper against a cycle-schedule reference model.
module tb_pll_phase_stepper;

  localparam int S      = 4;
  localparam int P      = 4;
  localparam int G      = 4;
  localparam int L      = 16;
  localparam int STEP_W = 8;
  localparam int ACC_W  = 4;

  logic              clk_i = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_sel = '0;
  logic              req_dir = 1'b0;
  logic [STEP_W-1:0] req_steps = '0;
  logic              done;
  logic              err;
  logic              err_clr = 1'b0;
  logic [1:0]        rd_sel = '0;
  logic [ACC_W-1:0]  rd_phase;
  logic              locked = 1'b1;
  logic [1:0]        phasesel;
  logic              phasedir;
  logic              phasestep;
  logic              phaseloadreg;

  logic [ACC_W-1:0]  model [4];
  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk_i = ~clk_i;

  pll_phase_stepper #(
    .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G), .LOCK_CYC(L),
    .STEP_W(STEP_W), .ACC_W(ACC_W)
  ) dut (
    .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps), .done(done),
    .err(err), .err_clr(err_clr), .rd_sel(rd_sel), .rd_phase(rd_phase),
    .locked(locked), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse k occupies cycles 1+S+k*(P+G) .. +P-1 after the accept cycle
  function automatic bit in_pulse(input int c, input int steps);
    for (int k = 0; k < steps; k++) begin
      if (c >= 1 + S + k * (P + G) && c <= S + P + k * (P + G)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Pulses whose last low cycle lies before cycle c and before lock was lost
  function automatic int pulses_before(input int c, input int steps, input int lockfall);
    int n = 0;
    for (int k = 0; k < steps; k++) begin
      if (S + P + k * (P + G) < c && S + P + k * (P + G) < lockfall) n++;
    end
    return n;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 300 && req_ready !== 1'b1; i++) @(negedge clk_i);
    if (req_ready !== 1'b1) check_eq("ready_wait", req_ready, 1);
  endtask

  task automatic measure_lock(input string tag);
    int n = 0;
    int bad = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_i);
      if (phasestep !== 1'b1) bad++;
      if (req_ready === 1'b1) begin
        n = i;
        break;
      end
    end
    check_eq(tag, n, L + 3);
    check_eq({tag, "_step_idle"}, bad, 0);
  endtask

  task automatic check_accs(input string tag);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      check_eq($sformatf("%s[%0d]", tag, s), rd_phase, model[s]);
    end
  endtask

  task automatic run_req(input logic [1:0] sel, input logic dir, input int steps, input int drop);
    int done_exp, lockfall, sign, done_n, done_cyc, bad_step, bad_acc;
    logic [ACC_W-1:0] start, exp_acc;
    sign     = (dir == 1'b0) ? 1 : -1;
    lockfall = (drop >= 0) ? drop + 2 : 32'h3fff_ffff;
    done_exp = (drop >= 0) ? drop + 3 : ((steps == 0) ? 1 : 1 + S + steps * (P + G));
    done_n   = 0;
    done_cyc = -1;
    bad_step = 0;
    bad_acc  = 0;
    wait_ready();
    start     = model[sel];
    req_valid = 1'b1;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = STEP_W'(steps);
    rd_sel    = sel;
    @(posedge clk_i);
    for (int c = 1; c <= done_exp + 1; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        check_eq("sel_latch", phasesel, sel);
        check_eq("dir_latch", phasedir, dir);
        req_valid = 1'b0;
        req_sel   = 2'($urandom);
        req_dir   = 1'($urandom);
        req_steps = STEP_W'($urandom);
      end
      exp_acc = ACC_W'(int'(start) + sign * pulses_before(c, steps, lockfall));
      if (phasestep !== !(in_pulse(c, steps) && c < done_exp)) bad_step++;
      if (phaseloadreg !== 1'b0) bad_step++;
      if (rd_phase !== exp_acc) bad_acc++;
      if (done === 1'b1) begin
        done_n++;
        done_cyc = c;
      end
      if (drop >= 0 && c == drop) locked = 1'b0;
      err_clr = (drop >= 0 && c == drop + 2);
      if (c == done_exp + 1) check_eq("ready_after_done", req_ready, (drop < 0));
    end
    err_clr = 1'b0;
    check_eq("step_wave_bad_cycles", bad_step, 0);
    check_eq("acc_trace_bad_cycles", bad_acc, 0);
    check_eq("done_count", done_n, 1);
    check_eq("done_cycle", done_cyc, done_exp);
    if (drop >= 0) check_eq("err_set_over_clr", err, 1);
    model[sel] = ACC_W'(int'(start) + sign * pulses_before(done_exp + 5, steps, lockfall));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    for (int s = 0; s < 4; s++) model[s] = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_phasesel", phasesel, 0);
    check_eq("rst_phasedir", phasedir, 0);
    check_eq("rst_phasestep", phasestep, 1);
    check_eq("rst_phaseloadreg", phaseloadreg, 0);
    check_accs("rst_acc");
    reset = 1'b0;
    measure_lock("lock_latency");

    run_req(2'd2, 1'b0, 3, -1);
    check_accs("single_shift_acc");
    run_req(2'd1, 1'b1, 9, -1);
    check_accs("advance_wrap_acc");
    run_req(2'd0, 1'b0, 0, -1);
    check_accs("zero_steps_acc");

    repeat (8) run_req(2'($urandom), 1'($urandom), int'($urandom_range(0, 12)), -1);
    check_accs("random_acc");

    // Lock dropped so that the filtered lock falls inside the second pulse
    run_req(2'($urandom), 1'($urandom), 5, 11 + int'($urandom_range(0, 3)));
    check_accs("lock_loss_acc");
    bad = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (req_ready !== 1'b0) bad++;
    end
    check_eq("ready_while_unlocked", bad, 0);
    locked = 1'b1;
    measure_lock("relock_latency");
    check_eq("err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk_i);
    err_clr = 1'b0;
    check_eq("err_cleared", err, 0);

    // Reset asserted during the first GAP of a 3-step advance on output 3
    wait_ready();
    req_valid = 1'b1;
    req_sel   = 2'd3;
    req_dir   = 1'b1;
    req_steps = STEP_W'(3);
    @(posedge clk_i);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk_i);
      if (c == 1) req_valid = 1'b0;
      if (c == 10) begin
        check_eq("pre_reset_phasesel", phasesel, 3);
        reset = 1'b1;
      end
    end
    for (int s = 0; s < 4; s++) model[s] = '0;
    check_eq("midrst_req_ready", req_ready, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_err", err, 0);
    check_eq("midrst_phasesel", phasesel, 0);
    check_eq("midrst_phasedir", phasedir, 0);
    check_eq("midrst_phasestep", phasestep, 1);
    check_accs("midrst_acc");
    reset = 1'b0;
    measure_lock("post_reset_lock");
    run_req(2'($urandom), 1'($urandom), int'($urandom_range(1, 6)), -1);
    check_accs("post_reset_acc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
